// File: rtl/mips_pkg.sv
// Shared types for the MIPS boot path: loader FSM states and image framing constants.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } t_boot_state;

    localparam int BOOT_LEN_BYTES = 2;

endpackage

// File: rtl/boot_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words and keeps a running XOR checksum.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [7:0]  o_checksum
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;
    logic [7:0]  r_checksum;

    // The completed word is latched separately so it stays stable during its write
    // cycle while the next word's first byte is already shifting in.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
            r_checksum   <= 8'd0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_valid) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_shift    <= {r_shift[15:0], i_byte};
                r_checksum <= r_checksum ^ i_byte;
                if (r_byte_cnt == 2'd3) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_last_byte  = (r_byte_cnt == 2'd3);
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_checksum   = r_checksum;

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, checksummed program image and writes it into instruction
// memory, holding the core in reset until a verified image is in place.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam int LEN_W = BOOT_LEN_BYTES * 8;
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [LEN_W-1:0] DEPTH_WORDS = LEN_W'(IMEM_DEPTH);

    t_boot_state      r_state;
    t_boot_state      w_next;
    logic [7:0]       r_len_hi;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_words_rx;
    logic [IDX_W-1:0] r_word_idx;

    logic             w_accept;
    logic             w_clear;
    logic             w_pack_valid;
    logic             w_last_byte;
    logic             w_word_valid;
    logic [31:0]      w_word;
    logic [7:0]       w_checksum;
    logic [LEN_W-1:0] w_len;

    assign w_accept     = in_valid & in_ready;
    assign w_len        = {r_len_hi, in_data};
    assign w_clear      = (w_next == LEN_HI) && (r_state != LEN_HI);
    assign w_pack_valid = w_accept && (r_state == DATA);

    boot_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_valid      (w_pack_valid),
        .i_byte       (in_data),
        .o_last_byte  (w_last_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_checksum   (w_checksum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (w_accept) begin
                    w_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_accept) begin
                    if (w_len > DEPTH_WORDS) begin
                        w_next = ERROR;
                    end else if (w_len == '0) begin
                        w_next = CHECK;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                // Leave on the last byte of the final word; its write lands in CHECK.
                if (w_accept && w_last_byte && (r_words_rx + LEN_W'(1) == r_len)) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_accept) begin
                    w_next = (in_data == w_checksum) ? DONE : ERROR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_len_hi   <= 8'd0;
            r_len      <= '0;
            r_words_rx <= '0;
            r_word_idx <= '0;
        end else begin
            if (r_state == LEN_HI && w_accept) begin
                r_len_hi <= in_data;
            end
            if (r_state == LEN_LO && w_accept) begin
                r_len <= w_len;
            end
            if (w_pack_valid && w_last_byte) begin
                r_words_rx <= r_words_rx + LEN_W'(1);
            end
            if (w_word_valid) begin
                r_word_idx <= r_word_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        core_rst = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        unique case (r_state)
            LEN_HI, LEN_LO, DATA, CHECK: in_ready = 1'b1;
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign imem_we    = w_word_valid;
    assign imem_addr  = {r_word_idx, 2'b00};
    assign imem_wdata = w_word;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: images are generated with a byte-level model,
// expected writes are queued up front and matched by an independent write monitor.
module tb_imem_boot_loader;

    localparam int DEPTH = 256;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } t_write;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    t_write      expQ[$];
    t_write      expW;
    logic [31:0] wordsQ[$];
    int          nChecks    = 0;
    int          nFails     = 0;
    int          writesSeen = 0;
    int          gapPct     = 0;

    always #5 clk = ~clk;

    imem_boot_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Write monitor: every pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            writesSeen++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, expected none", imem_addr, imem_wdata);
            end else begin
                expW = expQ.pop_front();
                checkOutput("write addr", {22'd0, imem_addr}, {22'd0, expW.addr});
                checkOutput("write data", imem_wdata, expW.data);
            end
        end
    end

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int waitCycles = 0;
        while ($urandom_range(0, 99) < gapPct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (in_ready !== 1'b1) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL byte handshake: in_ready stayed %b, expected 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends the image held in wordsQ; chkXor corrupts the checksum byte when nonzero.
    task automatic applyStimulus(input logic [7:0] chkXor, input int gap);
        int         n          = wordsQ.size();
        bit         oversize   = (n > DEPTH);
        bit         expectDone = !oversize && (chkXor == 8'd0);
        logic [7:0] chk        = 8'd0;
        logic [7:0] b;
        pulseStart();
        checkBit("armed core_rst", core_rst, 1'b1);
        checkBit("armed done", done, 1'b0);
        checkBit("armed error", error, 1'b0);
        checkBit("armed in_ready", in_ready, 1'b1);
        checkOutput("armed imem_addr", {22'd0, imem_addr}, 32'd0);
        gapPct     = gap;
        writesSeen = 0;
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                expQ.push_back('{addr: 10'(i * 4), data: wordsQ[i]});
            end
        end
        sendByte(8'(n >> 8));
        sendByte(8'(n));
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 3; k >= 0; k--) begin
                    b   = 8'(wordsQ[i] >> (8 * k));
                    chk = chk ^ b;
                    sendByte(b);
                end
            end
            sendByte(chk ^ chkXor);
        end
        gapPct = 0;
        checkBit("end done", done, expectDone);
        checkBit("end error", error, !expectDone);
        checkBit("end core_rst", core_rst, !expectDone);
        checkBit("end in_ready", in_ready, 1'b0);
        checkOutput("write count", writesSeen, oversize ? 0 : n);
        checkOutput("pending writes", expQ.size(), 0);
        repeat (2) @(negedge clk);
        checkBit("held done", done, expectDone);
        checkBit("held core_rst", core_rst, !expectDone);
    endtask

    task automatic loadTwoWord();
        wordsQ.delete();
        wordsQ.push_back(32'h2008_0005);
        wordsQ.push_back(32'hAC08_0000);
    endtask

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] resetBytes[6];
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkBit("reset in_ready", in_ready, 1'b0);
        checkBit("reset imem_we", imem_we, 1'b0);
        checkOutput("reset imem_addr", {22'd0, imem_addr}, 32'd0);
        checkOutput("reset imem_wdata", imem_wdata, 32'd0);
        checkBit("reset core_rst", core_rst, 1'b1);
        checkBit("reset done", done, 1'b0);
        checkBit("reset error", error, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkBit("idle in_ready", in_ready, 1'b0);

        $display("[TB] two-word load");
        loadTwoWord();
        applyStimulus(8'h00, 0);

        $display("[TB] zero-length load");
        wordsQ.delete();
        applyStimulus(8'h00, 0);

        $display("[TB] oversize length");
        wordsQ.delete();
        for (int i = 0; i < DEPTH + 1; i++) wordsQ.push_back($urandom);
        applyStimulus(8'h00, 0);

        $display("[TB] bad checksum then recovery");
        loadTwoWord();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);

        $display("[TB] gaps on in_valid");
        applyStimulus(8'h00, 40);

        $display("[TB] reset mid-load");
        pulseStart();
        resetBytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        expQ.push_back('{addr: 10'd0, data: 32'h2008_0005});
        for (int i = 0; i < 6; i++) sendByte(resetBytes[i]);
        rst = 1'b1;
        @(negedge clk);
        checkBit("mid-reset in_ready", in_ready, 1'b0);
        checkBit("mid-reset imem_we", imem_we, 1'b0);
        checkBit("mid-reset core_rst", core_rst, 1'b1);
        checkBit("mid-reset done", done, 1'b0);
        checkOutput("mid-reset imem_addr", {22'd0, imem_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset pending writes", expQ.size(), 0);
        applyStimulus(8'h00, 0);

        $display("[TB] full-depth load");
        wordsQ.delete();
        for (int i = 0; i < DEPTH; i++) wordsQ.push_back($urandom);
        applyStimulus(8'h00, 0);

        $display("[TB] random loads");
        for (int t = 0; t < 15; t++) begin
            wordsQ.delete();
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) wordsQ.push_back($urandom);
            applyStimulus(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                          int'($urandom_range(0, 50)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer-side counterpart to the core's instruction fetch path: receives a program as a byte stream, packs it into 32-bit words, and writes them into instruction memory.
- Holds the MIPS core in reset until a complete, checksum-verified image has been written.
- Sits between a byte source (UART RX or testbench) and the instruction memory write port; drives the core's reset.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 10, width of the byte address presented to instruction memory; matches the PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a load from IDLE, DONE or ERROR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word
- imem_addr  out  ADDR_W  byte address of the word being written; always word-aligned
- imem_wdata  out  32  word being written
- core_rst  out  1  reset to the MIPS core; high unless in DONE
- done  out  1  high in DONE
- error  out  1  high in ERROR

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; core_rst=1; done=0; error=0; byte and word counters 0; checksum 0.
- Handshake: a byte transfers when in_valid & in_ready are both high at a rising edge. in_valid may drop at any time without loss.
- Image format, all fields MSB first:
  - LEN: 2 bytes, word count N.
  - N words of 4 bytes each.
  - CHK: 1 byte, XOR of all 4N payload bytes. LEN bytes are not included.
- States and transitions:
  - IDLE: in_ready=0. start -> LEN_HI.
  - LEN_HI: in_ready=1. Accept the high byte -> LEN_LO.
  - LEN_LO: in_ready=1. Accept the low byte, then:
    - N > IMEM_DEPTH -> ERROR.
    - N == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: in_ready=1. Bytes shift into the pack register MSB first, and each byte is XORed into the checksum.
    - The cycle after the 4th byte of a word is accepted: imem_we=1 for exactly one cycle, with imem_addr=4*word_index and imem_wdata=the packed word.
    - After the write, word_index increments.
    - After the N-th word is accepted -> CHECK. The final write pulse still occurs in the CHECK entry cycle.
  - CHECK: in_ready=1. Accept one byte:
    - equal to the checksum -> DONE.
    - not equal -> ERROR.
  - DONE: in_ready=0, core_rst=0, done=1. start -> LEN_HI; core_rst returns to 1 in the same cycle the state changes.
  - ERROR: in_ready=0, core_rst=1, error=1. start -> LEN_HI, clearing error.
- Whenever LEN_HI is entered: counters, checksum and imem_addr are cleared.
- start outside IDLE, DONE and ERROR is ignored.
- Sustained throughput: one byte per cycle in DATA, with no stalls at word boundaries. in_ready never drops because of a pending write.
- imem_addr wraps modulo 2^ADDR_W. This is unreachable when IMEM_DEPTH*4 <= 2^ADDR_W, which is a required parameter constraint.
- Memory already written before an ERROR is left as is; the core stays in reset.
- rst asserted mid-load returns the block to IDLE next cycle with core_rst=1. A partial image is never released.
- Simultaneous rst and start: rst wins.

Decomposition:
- mips_pkg gains:
  - typedef enum t_boot_state {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR}.
  - localparam BOOT_LEN_BYTES=2.
- Sub-module boot_word_packer:
  - Inputs: byte shift-in, valid strobe, clear.
  - Outputs: the 32-bit word and a word_valid pulse.
  - Holds a 2-bit byte counter and the XOR checksum accumulator.
- The FSM, address/word counters and memory-side outputs stay in imem_boot_loader.

Test Plan:
- Two-word load: start, then bytes 00 02 | 20 08 00 05 | AC 08 00 00 | 89 -> writes 0x20080005 @0x000 and 0xAC080000 @0x004; done=1; core_rst falls to 0.
- Zero length: bytes 00 00 00 -> no imem_we; DONE; core_rst=0.
- Oversize: with IMEM_DEPTH=256, bytes 01 01 -> ERROR right after LEN_LO; in_ready=0; core_rst=1; no writes.
- Bad checksum: the two-word image with CHK=0x88 -> both writes occur, then ERROR; error=1; core_rst stays 1. A following start plus a correct image -> DONE.
- Backpressure and gaps: the two-word image with in_valid low on random cycles -> identical writes and addresses; exactly 2 imem_we pulses.
- Reset mid-load: rst after the 6th byte -> IDLE next cycle, imem_we=0, core_rst=1. A following start plus the full image -> correct DONE.
